// File: rtl/dmem_lane.sv
// Byte-addressable data memory for the load/store path: little-endian 32-bit words,
// byte/half/word access with extension, error checking, and a post-reset scrub.
module dmem_lane #(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = AW - 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state;
    logic [IW-1:0] clr_idx;
    logic [31:0]   mem [WORDS];

    logic          acc;
    logic          err;
    logic [IW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : 32'(b);
            2'b01:   return uns ? {16'b0, h} : 32'(h);
            default: return word;
        endcase
    endfunction

    assign busy      = (state == CLEAR);
    assign req_ready = (state == RUN) && (!resp_valid || resp_ready);
    assign acc       = req_valid && req_ready;
    assign word_idx  = req_addr[AW-1:2];

    // Upper address bits must be zero, so the range check is a plain OR-reduce.
    assign err = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (|req_addr[31:AW]);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rd_word = mem[word_idx];
    assign ld_data = load_extend(rd_word, req_addr[1:0], req_size, req_unsigned);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clr_idx <= clr_idx + IW'(1);
                if (clr_idx == LAST_IDX) state <= RUN;
            end
            // A new accept overwrites the response being popped in the same cycle.
            if (acc) begin
                resp_valid <= 1'b1;
                resp_err   <= err;
                resp_data  <= (err || req_write) ? 32'd0 : ld_data;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Storage carries no reset; the scrub walk zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (acc && req_write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_lane.sv
// Randomized and directed bench for dmem_lane, scored against a byte-array memory model
// and an in-order queue of expected responses.
module tb_dmem_lane;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    dmem_lane #(.DEPTH_BYTES(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mdl [DEPTH];
    exp_t        exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: plain byte array, power-of-two sizes, arithmetic sign extension.
    task automatic mdl_access(input logic w, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output exp_t e);
        int n;
        longint unsigned val;
        n = 1 << sz;
        e.err  = (sz == 2'd3) || ((a % n) != 0) || (a >= DEPTH);
        e.data = 32'd0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                val = 0;
                for (int i = 0; i < n; i++) val = val | (longint'(mdl[int'(a) + i]) << (8 * i));
                if (!uns && n < 4 && ((val >> (8 * n - 1)) & 1) == 1)
                    val = val - (64'd1 << (8 * n));
                e.data = val[31:0];
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                end
            end
            if (req_valid && req_ready) begin
                mdl_access(req_write, req_size, req_unsigned, req_addr, req_wdata, e);
                exp_q.push_back(e);
            end
        end
    end

    // Starts and ends one time unit after a rising edge; accept happens at the final edge.
    task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int tries = 0;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            tries++;
            if (tries > 50) begin
                chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
                break;
            end
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] d, output logic e);
        send(w, sz, uns, a, wd);
        chk("resp_latency", {31'b0, resp_valid}, 32'd1);
        d = resp_data;
        e = resp_err;
    endtask

    task automatic ld_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        xfer(1'b0, sz, uns, a, 32'd0, d, e);
        chk(tag, d, exp);
    endtask

    task automatic err_chk(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] d;
        logic        e;
        xfer(w, sz, 1'b0, a, wd, d, e);
        chk({tag, "_err"}, {31'b0, e}, 32'd1);
        chk({tag, "_data"}, d, 32'd0);
    endtask

    task automatic do_reset();
        int cnt = 0;
        #2;
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("busy_cycles", 32'(cnt), 32'(DEPTH / 4));
        chk("ready_after_scrub", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d0, d;
        logic        e0, e;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b1;

        do_reset();

        for (int i = 0; i < DEPTH; i += 4) ld_chk("scrub_zero", 2'b10, 1'b0, 32'(i), 32'd0);

        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, d, e);
        chk("store_resp_data", d, 32'd0);
        ld_chk("lb_10", 2'b00, 1'b0, 32'h10, 32'hFFFFFFEF);
        ld_chk("lb_11", 2'b00, 1'b0, 32'h11, 32'hFFFFFFBE);
        ld_chk("lb_12", 2'b00, 1'b0, 32'h12, 32'hFFFFFFAD);
        ld_chk("lb_13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
        ld_chk("lhu_12", 2'b01, 1'b1, 32'h12, 32'h0000DEAD);
        ld_chk("lh_12", 2'b01, 1'b0, 32'h12, 32'hFFFFDEAD);
        ld_chk("lbu_13", 2'b00, 1'b1, 32'h13, 32'h000000DE);

        xfer(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, d, e);
        ld_chk("sb_merge", 2'b10, 1'b0, 32'h10, 32'hDEAD5AEF);
        xfer(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, d, e);
        ld_chk("sh_merge", 2'b10, 1'b1, 32'h10, 32'h12345AEF);

        xfer(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, d, e);
        err_chk("e_half_mis", 1'b1, 2'b01, 32'h15, 32'hFFFFFFFF);
        err_chk("e_word_mis", 1'b0, 2'b10, 32'h16, 32'd0);
        err_chk("e_size11", 1'b1, 2'b11, 32'h14, 32'h0);
        err_chk("e_range", 1'b0, 2'b10, 32'(DEPTH), 32'd0);
        err_chk("e_range_hi", 1'b1, 2'b00, 32'h8000_0014, 32'h11);
        ld_chk("e_word_intact", 2'b10, 1'b0, 32'h14, 32'hCAFEF00D);

        // Backpressure: hold the response, park a second request behind it.
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        resp_ready = 1'b0;
        d0 = resp_data;
        e0 = resp_err;
        chk("bp_first_data", d0, 32'h12345AEF);
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h14; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_data", resp_data, d0);
            chk("bp_err", {31'b0, resp_err}, {31'b0, e0});
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        send(1'b0, 2'b00, 1'b1, 32'h14, 32'd0);
        chk("bp_parked", resp_data, 32'h0000000D);

        for (int i = 0; i < 8; i++) begin
            send(1'b0, 2'(i % 3), 1'(i[2]), 32'h10 + 32'(4 * (i % 2)), 32'd0);
            chk("stream_valid", {31'b0, resp_valid}, 32'd1);
        end

        for (int i = 0; i < 200; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r  = $urandom_range(0, 15);
            if (r == 0)      a = 32'(DEPTH) + $urandom_range(0, 15);
            else if (r == 1) a = 32'h1000_0000 | $urandom_range(0, DEPTH - 1);
            else             a = $urandom_range(0, DEPTH - 1);
            if (r >= 2 && r < 13 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            resp_ready = ($urandom_range(0, 3) != 0);
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a back-to-back stream.
        xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'h5A5A5A5A, d, e);
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, d, e);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        ld_chk("post_rst_20", 2'b10, 1'b0, 32'h20, 32'd0);
        ld_chk("post_rst_10", 2'b10, 1'b0, 32'h10, 32'd0);
        ld_chk("post_rst_14", 2'b10, 1'b0, 32'h14, 32'd0);
        @(posedge clk);
        #1;
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
